cube_tile_buffer: RTL and testbench

- Parametrised successor to the single-tile cube data buffer.
- Accepts narrow input beats and assembles them into full CH×ROWS×COLS activation tiles for the CNN layer.
- Double-buffered (ping-pong): the next tile fills while the current tile is held for the consumer.
- Adds valid/ready handshakes on both sides and a flush that zero-pads a partial tile.

---
 rtl/cube_tile_buffer_pkg.sv | 11 +
 rtl/tile_bank.sv | 45 ++++
 rtl/cube_tile_buffer.sv | 63 ++++++
 tb/tb_cube_tile_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cube_tile_buffer_pkg.sv
// cube_tile_buffer_pkg: shared data-length default, bank-state encoding and tile-geometry helpers
package cube_tile_buffer_pkg;
  localparam int DEF_DATA_LEN = 16;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_t;
  function automatic int tile_beats(input int ch, input int rows, input int cols, input int in_elems);
    return ch * rows * cols / in_elems;
  endfunction
  function automatic int tile_w(input int ch, input int rows, input int cols, input int data_len);
    return ch * rows * cols * data_len;
  endfunction
endpackage

// File: rtl/tile_bank.sv
// tile_bank: one ping-pong bank (clk, rst, we/beat write, flush, rel release -> state, done, tile, q_beats)
module tile_bank
  import cube_tile_buffer_pkg::*;
#(
  parameter int IN_W = 128,
  parameter int BEATS = 48,
  localparam int BW = $clog2(BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  flush,
  input  logic                  rel,
  input  logic [IN_W-1:0]       beat,
  output bank_state_t           state,
  output logic                  done,
  output logic [BEATS*IN_W-1:0] tile,
  output logic [BW-1:0]         q_beats
);
  logic [BW-1:0] cnt, nxt;
  assign nxt  = cnt + BW'(we);
  assign done = (we && cnt == BW'(BEATS - 1)) || (flush && (cnt != '0 || we));
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      cnt     <= '0;
      q_beats <= '0;
    end else if (done) begin
      state   <= FULL;
      cnt     <= '0;
      q_beats <= nxt;
    end else if (we) begin
      state <= FILLING;
      cnt   <= nxt;
    end else if (rel) begin
      state <= EMPTY;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < BEATS; k++) begin
      if (we && cnt == BW'(k)) tile[k*IN_W +: IN_W] <= beat;
      else if (done && BW'(k) >= nxt) tile[k*IN_W +: IN_W] <= '0;
    end
  end
endmodule

// File: rtl/cube_tile_buffer.sv
// cube_tile_buffer: ping-pong tile assembler (in_valid/in_ready/in_data/in_flush -> out_valid/out_ready/q/q_beats)
module cube_tile_buffer
  import cube_tile_buffer_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int CH = 32,
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int IN_ELEMS = 8,
  localparam int BEATS = tile_beats(CH, ROWS, COLS, IN_ELEMS),
  localparam int IN_W = IN_ELEMS * DATA_LEN,
  localparam int TILE_W = BEATS * IN_W,
  localparam int BW = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TILE_W-1:0] q,
  output logic [BW-1:0]     q_beats
);
  if ((CH * ROWS * COLS) % IN_ELEMS != 0) begin : g_bad_geometry
    $error("CH*ROWS*COLS must be a multiple of IN_ELEMS");
  end
  bank_state_t       st [2];
  logic              done_v [2];
  logic [TILE_W-1:0] tile_v [2];
  logic [BW-1:0]     qb_v [2];
  logic              wbank, rbank, acc, take;
  assign in_ready  = st[wbank] != FULL;
  assign out_valid = st[rbank] == FULL;
  assign acc       = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign q         = out_valid ? tile_v[rbank] : '0;
  assign q_beats   = out_valid ? qb_v[rbank] : '0;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(.IN_W(IN_W), .BEATS(BEATS)) u_bank (
      .clk(clk),
      .rst(rst),
      .we(acc && wbank == 1'(b)),
      .flush(in_flush && in_ready && wbank == 1'(b)),
      .rel(take && rbank == 1'(b)),
      .beat(in_data),
      .state(st[b]),
      .done(done_v[b]),
      .tile(tile_v[b]),
      .q_beats(qb_v[b])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
    end else begin
      if (done_v[wbank]) wbank <= ~wbank;
      if (take) rbank <= ~rbank;
    end
  end
endmodule

// File: tb/tb_cube_tile_buffer.sv
// tb_cube_tile_buffer: scoreboard bench for cube_tile_buffer at default parameters
module tb_cube_tile_buffer;
  localparam int IN_W = 128;
  localparam int BEATS = 48;
  localparam int TILE_W = 6144;
  localparam int BW = 6;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_flush = 1'b0;
  logic              out_ready = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_ready, out_valid;
  logic [TILE_W-1:0] q;
  logic [BW-1:0]     q_beats;
  typedef struct {
    logic [TILE_W-1:0] q;
    int                nb;
  } exp_t;
  exp_t              expq[$];
  logic [TILE_W-1:0] mt;
  int                mc = 0;
  int                checks = 0;
  int                failures = 0;
  int                stalls = 0;
  int                pops = 0;
  cube_tile_buffer dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_flush(in_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q(q),
    .q_beats(q_beats)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic chk_tile(input string name, input logic [TILE_W-1:0] got, input logic [TILE_W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = BEATS - 1; k >= 0; k--) if (got[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) bad = k;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s beat %0d got=%0h expected=%0h", name, bad, got[bad*IN_W +: IN_W], exp[bad*IN_W +: IN_W]);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tile got=tile expected=none");
      end else begin
        e = expq.pop_front();
        chk_tile("tile_data", q, e.q);
        chk("tile_q_beats", 128'(q_beats), 128'(e.nb));
        pops++;
      end
    end
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [IN_W-1:0] d, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_flush = f;
    while (!in_ready && n < 2000) begin
      stalls++;
      sync();
      n++;
    end
    if (n == 2000) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout got=in_ready_low expected=accept");
      in_valid = 1'b0;
      in_flush = 1'b0;
    end else begin
      sync();
      in_valid = 1'b0;
      in_flush = 1'b0;
      mt[mc*IN_W +: IN_W] = d;
      mc++;
      if (mc == BEATS || f) begin
        expq.push_back('{mt, mc});
        mt = '0;
        mc = 0;
      end
    end
  endtask
  task automatic flush_only();
    in_flush = 1'b1;
    sync();
    in_flush = 1'b0;
    if (mc > 0) begin
      expq.push_back('{mt, mc});
      mt = '0;
      mc = 0;
    end
  endtask
  task automatic rel_pulse();
    sync();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
  endtask
  initial begin
    int p0;
    logic [IN_W-1:0] ones;
    mt = '0;
    ones = '1;
    repeat (2) sync();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_q_beats", 128'(q_beats), 128'(0));
    chk_tile("rst_q", q, '0);
    sync();
    stalls = 0;
    for (int k = 0; k < 48; k++) beat({8{16'(k)}}, 1'b0);
    @(negedge clk);
    chk("t1_no_stall", 128'(stalls), 128'(0));
    chk("t1_out_valid", 128'(out_valid), 128'(1));
    chk("t1_q_low", q[127:0], 128'(0));
    chk("t1_q_high", q[6143:6016], {8{16'h002F}});
    chk("t1_q_beats", 128'(q_beats), 128'(48));
    sync();
    for (int k = 48; k < 96; k++) beat({8{16'(k)}}, 1'b0);
    @(negedge clk);
    chk("t2_in_ready_low", 128'(in_ready), 128'(0));
    chk("t2_out_valid_hold", 128'(out_valid), 128'(1));
    chk("t2_q_hold", q[6143:6016], {8{16'h002F}});
    chk("t2_q_beats_hold", 128'(q_beats), 128'(48));
    rel_pulse();
    @(negedge clk);
    chk("t2_out_valid_next", 128'(out_valid), 128'(1));
    chk("t2_in_ready_back", 128'(in_ready), 128'(1));
    chk("t2_q_tile2", q[127:0], {8{16'd48}});
    rel_pulse();
    for (int k = 0; k < 5; k++) beat(ones, 1'b0);
    flush_only();
    @(negedge clk);
    chk("t3_out_valid", 128'(out_valid), 128'(1));
    chk("t3_q_beats", 128'(q_beats), 128'(5));
    chk("t3_low_ones", 128'(&q[639:0]), 128'(1));
    chk("t3_high_zero", 128'(|q[6143:640]), 128'(0));
    rel_pulse();
    beat({4{32'h1234_5678}}, 1'b1);
    @(negedge clk);
    chk("t4_q_beats", 128'(q_beats), 128'(1));
    chk("t4_q_low", q[127:0], {4{32'h1234_5678}});
    chk("t4_high_zero", 128'(|q[6143:128]), 128'(0));
    rel_pulse();
    flush_only();
    @(negedge clk);
    chk("t4_empty_flush_valid", 128'(out_valid), 128'(0));
    chk("t4_empty_flush_ready", 128'(in_ready), 128'(1));
    sync();
    out_ready = 1'b1;
    stalls = 0;
    p0 = pops;
    for (int k = 0; k < 96; k++) beat({8{16'(k * 7 + 3)}}, 1'b0);
    repeat (3) sync();
    out_ready = 1'b0;
    chk("t5_no_stall", 128'(stalls), 128'(0));
    chk("t5_tiles", 128'(pops - p0), 128'(2));
    chk("t5_drained", 128'(expq.size()), 128'(0));
    for (int k = 0; k < 68; k++) beat({8{16'hBEEF ^ 16'(k)}}, 1'b0);
    rst = 1'b1;
    expq.delete();
    mt = '0;
    mc = 0;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", 128'(out_valid), 128'(0));
    chk_tile("t6_q_zero", q, '0);
    chk("t6_q_beats", 128'(q_beats), 128'(0));
    chk("t6_in_ready", 128'(in_ready), 128'(1));
    sync();
    for (int k = 0; k < 48; k++) beat({8{16'h00A5 + 16'(k)}}, 1'b0);
    @(negedge clk);
    chk("t6_fresh_q_beats", 128'(q_beats), 128'(48));
    rel_pulse();
    for (int k = 0; k < 5; k++) beat({8{16'h0C00 + 16'(k)}}, 1'b0);
    flush_only();
    rel_pulse();
    repeat (3) sync();
    chk("final_drained", 128'(expq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
